// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: condition-mode encodings and FSM states.
package branch_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t BR_ANY     = 3'd0;
  localparam mode_t BR_NONE    = 3'd1;
  localparam mode_t BR_ALL     = 3'd2;
  localparam mode_t BR_ALLCLR  = 3'd3;
  localparam mode_t BR_ALWAYS  = 3'd4;
  localparam mode_t BR_NEVER   = 3'd5;
  localparam mode_t BR_ONEHOT  = 3'd6;
  localparam mode_t BR_ILLEGAL = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EVAL = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: (mask, mode, flags) -> (take, err).
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int FLAG_W = 32
) (
  input  logic [FLAG_W-1:0] mask_i,
  input  mode_t             mode_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              take_o,
  output logic              err_o
);

  localparam logic [FLAG_W-1:0] ONE = FLAG_W'(1);

  logic [FLAG_W-1:0] m;
  logic              one_hot;

  assign m       = mask_i & flags_i;
  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign one_hot = (m != '0) && ((m & (m - ONE)) == '0);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    take_o = 1'b0;
    err_o  = 1'b0;
    case (mode_i)
      BR_ANY:    take_o = (m != '0);
      BR_NONE:   take_o = (m == '0);
      BR_ALL:    take_o = (m == mask_i);
      BR_ALLCLR: take_o = ((mask_i & ~flags_i) == mask_i);
      BR_ALWAYS: take_o = 1'b1;
      BR_NEVER:  take_o = 1'b0;
      BR_ONEHOT: take_o = one_hot;
      default:   err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Registered branch-condition unit with its own flags register and valid/ready handshake.
// Optional taken/not-taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_unit
  import branch_pkg::*;
#(
  parameter int FLAG_W = 32,
  parameter int MASK_W = 4,
  parameter int OPC_W  = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_wdata,
  output logic [FLAG_W-1:0] flags,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPC_W-1:0]  opcode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              take_branch,
  output logic              mode_err,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
);

  state_t            state_q, state_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  mode_t             mode_q, mode_d;
  logic              take_q, take_d;
  logic              err_q, err_d;
  logic              cond_take, cond_err;
  logic              unused_opcode;

  // Bits above the mode field carry no meaning here; folding them keeps them visibly consumed.
  assign unused_opcode = ^opcode;

  branch_cond_eval #(
    .FLAG_W (FLAG_W)
  ) u_cond (
    .mask_i  (FLAG_W'(mask_q)),
    .mode_i  (mode_q),
    .flags_i (flags_q),
    .take_o  (cond_take),
    .err_o   (cond_err)
  );

  assign flags_d = flag_we ? flag_wdata : flags_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    take_d  = take_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mask_d  = opcode[MASK_W-1:0];
          mode_d  = opcode[MASK_W+MODE_W-1:MASK_W];
          state_d = EVAL;
        end
      end
      // Evaluation uses the registered flags, so an EVAL-cycle write lands only afterwards.
      EVAL: begin
        take_d  = cond_take;
        err_d   = cond_err;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      flags_q <= '0;
      mask_q  <= '0;
      mode_q  <= BR_ANY;
      take_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      take_q  <= take_d;
      err_q   <= err_d;
    end
  end

  assign flags       = flags_q;
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign take_branch = take_q;
  assign mode_err    = err_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;
  logic             xfer;

  assign xfer = (state_q == RESP) && resp_ready;

  // Illegal-mode responses have take_q low and therefore land in the not-taken count.
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (xfer) begin
      if (take_q) taken_cnt_d    = taken_cnt_q + CNT_W'(1);
      else        nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`else
  assign taken_cnt    = '0;
  assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: condition table plus handshake, timing and reset sequences.
module tb_branch_unit;
  import branch_pkg::*;

  localparam int FLAG_W = 32;
  localparam int MASK_W = 4;
  localparam int OPC_W  = 11;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flag_we;
  logic [FLAG_W-1:0] flag_wdata;
  logic [FLAG_W-1:0] flags;
  logic              req_valid;
  logic              req_ready;
  logic [OPC_W-1:0]  opcode;
  logic              resp_valid;
  logic              resp_ready;
  logic              take_branch;
  logic              mode_err;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  nottaken_cnt;

  branch_unit #(
    .FLAG_W (FLAG_W),
    .MASK_W (MASK_W),
    .OPC_W  (OPC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flag_we      (flag_we),
    .flag_wdata   (flag_wdata),
    .flags        (flags),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .opcode       (opcode),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .take_branch  (take_branch),
    .mode_err     (mode_err),
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference statistics, wrapping at CNT_W bits like the hardware.
  logic [CNT_W-1:0] m_taken = '0;
  logic [CNT_W-1:0] m_nt    = '0;

  typedef struct {
    string       name;
    logic [31:0] flg;
    logic [3:0]  upper;
    mode_t       mode;
    logic [3:0]  mask;
    logic        take;
    logic        err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OPC_W-1:0] mk_opc(input logic [3:0] upper, input mode_t mode,
                                             input logic [3:0] mask);
    return {upper, mode, mask};
  endfunction

  task automatic check_cnts(input string name);
`ifdef BRANCH_STATS_EN
    check({name, "_taken_cnt"}, 64'(taken_cnt), 64'(m_taken));
    check({name, "_nottaken_cnt"}, 64'(nottaken_cnt), 64'(m_nt));
`else
    check({name, "_cnts_tied0"}, 64'({taken_cnt, nottaken_cnt}), 64'(0));
`endif
  endtask

  task automatic note_xfer(input logic t);
    if (t) m_taken = m_taken + 1'b1;
    else   m_nt    = m_nt + 1'b1;
  endtask

  task automatic set_flags(input logic [FLAG_W-1:0] v);
    flag_we    = 1'b1;
    flag_wdata = v;
    @(negedge clk);
    flag_we    = 1'b0;
  endtask

  // Issue one request from IDLE with resp_ready high; returns the response fields.
  task automatic run_req(input string name, input logic [OPC_W-1:0] opc,
                         output logic t, output logic e);
    int n;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    opcode     = opc;
    @(negedge clk);
    req_valid  = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_resp_seen"}, 64'(resp_valid), 64'(1));
    t = take_branch;
    e = mode_err;
    @(negedge clk);
    if (resp_valid === 1'b0) note_xfer(t);
    check({name, "_done"}, 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic t, e;
    int   cyc[3];
    logic tk[3];
    int   issued, got;
    logic rdy_before;

    vecs[0]  = '{"any_hit",      32'h5,         4'h0, BR_ANY,     4'h4, 1'b1, 1'b0};
    vecs[1]  = '{"any_zero",     32'h0,         4'h0, BR_ANY,     4'hF, 1'b0, 1'b0};
    vecs[2]  = '{"any_mask0",    32'hA,         4'h0, BR_ANY,     4'h0, 1'b0, 1'b0};
    vecs[3]  = '{"any_highflg",  32'hFFFF_FFF0, 4'h0, BR_ANY,     4'hF, 1'b0, 1'b0};
    vecs[4]  = '{"none_hit",     32'hA,         4'h0, BR_NONE,    4'h5, 1'b1, 1'b0};
    vecs[5]  = '{"none_miss",    32'hA,         4'h0, BR_NONE,    4'h2, 1'b0, 1'b0};
    vecs[6]  = '{"all_mask0",    32'hA,         4'h0, BR_ALL,     4'h0, 1'b1, 1'b0};
    vecs[7]  = '{"all_hit",      32'hA,         4'h0, BR_ALL,     4'hA, 1'b1, 1'b0};
    vecs[8]  = '{"all_miss",     32'hA,         4'h0, BR_ALL,     4'hB, 1'b0, 1'b0};
    vecs[9]  = '{"allclr_hit",   32'hA,         4'h0, BR_ALLCLR,  4'h5, 1'b1, 1'b0};
    vecs[10] = '{"allclr_miss",  32'hA,         4'h0, BR_ALLCLR,  4'h6, 1'b0, 1'b0};
    vecs[11] = '{"always",       32'hA,         4'h0, BR_ALWAYS,  4'h0, 1'b1, 1'b0};
    vecs[12] = '{"never",        32'hF,         4'h0, BR_NEVER,   4'hF, 1'b0, 1'b0};
    vecs[13] = '{"onehot_two",   32'hA,         4'h0, BR_ONEHOT,  4'hF, 1'b0, 1'b0};
    vecs[14] = '{"onehot_one",   32'hA,         4'h0, BR_ONEHOT,  4'h2, 1'b1, 1'b0};
    vecs[15] = '{"onehot_zero",  32'hA,         4'h0, BR_ONEHOT,  4'h5, 1'b0, 1'b0};
    vecs[16] = '{"illegal",      32'hA,         4'h0, BR_ILLEGAL, 4'hF, 1'b0, 1'b1};
    vecs[17] = '{"upper_ignored",32'h5,         4'hF, BR_ANY,     4'h4, 1'b1, 1'b0};

    reset      = 1'b1;
    flag_we    = 1'b0;
    flag_wdata = '0;
    req_valid  = 1'b0;
    opcode     = '0;
    resp_ready = 1'b0;
    #2;
    check("reset_outputs", 64'({flags, resp_valid, take_branch, mode_err}), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(1));
    check_cnts("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      set_flags(vecs[i].flg);
      check({vecs[i].name, "_flags"}, 64'(flags), 64'(vecs[i].flg));
      run_req(vecs[i].name, mk_opc(vecs[i].upper, vecs[i].mode, vecs[i].mask), t, e);
      check({vecs[i].name, "_take"}, 64'(t), 64'(vecs[i].take));
      check({vecs[i].name, "_err"}, 64'(e), 64'(vecs[i].err));
    end
    check_cnts("table");

    // Flag write in the accept cycle is seen by the evaluation.
    set_flags('0);
    resp_ready = 1'b1;
    flag_we    = 1'b1;
    flag_wdata = 32'h5;
    req_valid  = 1'b1;
    opcode     = mk_opc(4'h0, BR_ANY, 4'h4);
    @(negedge clk);
    flag_we    = 1'b0;
    req_valid  = 1'b0;
    check("fwd_eval_state", 64'({resp_valid, req_ready}), 64'(2'b00));
    check("fwd_flags", 64'(flags), 64'(32'h5));
    @(negedge clk);
    check("fwd_latency", 64'(resp_valid), 64'(1));
    check("fwd_take", 64'(take_branch), 64'(1));
    t = take_branch;
    @(negedge clk);
    note_xfer(t);
    check("fwd_ready", 64'(req_ready), 64'(1));

    // Flag write in the EVAL cycle is not seen.
    set_flags('0);
    req_valid = 1'b1;
    opcode    = mk_opc(4'h0, BR_ANY, 4'h4);
    @(negedge clk);
    req_valid  = 1'b0;
    flag_we    = 1'b1;
    flag_wdata = 32'h5;
    @(negedge clk);
    flag_we = 1'b0;
    check("nofwd_valid", 64'(resp_valid), 64'(1));
    check("nofwd_take", 64'(take_branch), 64'(0));
    check("nofwd_flags", 64'(flags), 64'(32'h5));
    t = take_branch;
    @(negedge clk);
    note_xfer(t);
    check_cnts("fwd");

    // Illegal mode held under backpressure.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    opcode     = mk_opc(4'h0, BR_ILLEGAL, 4'h3);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({resp_valid, req_ready, take_branch, mode_err}), 64'(4'b1001));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    note_xfer(1'b0);
    check("bp_release", 64'({resp_valid, req_ready}), 64'(2'b01));
    check_cnts("bp");

    // Back-to-back: always, never, never.
    issued     = 0;
    got        = 0;
    req_valid  = 1'b1;
    opcode     = mk_opc(4'h0, BR_ALWAYS, 4'h0);
    rdy_before = req_ready;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(negedge clk);
      if (rdy_before && req_valid) begin
        issued++;
        if (issued < 3) opcode = mk_opc(4'h0, BR_NEVER, 4'hF);
        else            req_valid = 1'b0;
      end
      if (resp_valid) begin
        cyc[got] = c;
        tk[got]  = take_branch;
        note_xfer(take_branch);
        got++;
      end
      rdy_before = req_ready;
    end
    req_valid = 1'b0;
    check("b2b_count", 64'(got), 64'(3));
    if (got == 3) begin
      check("b2b_gap1", 64'(cyc[1] - cyc[0]), 64'(3));
      check("b2b_gap2", 64'(cyc[2] - cyc[1]), 64'(3));
      check("b2b_takes", 64'({tk[0], tk[1], tk[2]}), 64'(3'b100));
    end
    @(negedge clk);
    check_cnts("b2b");

    // Five taken responses walk the 2-bit counter past its wrap point.
    for (int i = 0; i < 5; i++) begin
      run_req("wrap", mk_opc(4'h0, BR_ALWAYS, 4'h0), t, e);
    end
    check_cnts("wrap");

    // Reset while a response is pending.
    set_flags(32'h3C);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    opcode     = mk_opc(4'h0, BR_ALWAYS, 4'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", 64'({resp_valid, take_branch}), 64'(2'b11));
    #2;
    reset = 1'b1;
    #1;
    m_taken = '0;
    m_nt    = '0;
    check("rst_immediate", 64'({flags, resp_valid, take_branch, mode_err}), 64'(0));
    check_cnts("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after", 64'({req_ready, resp_valid}), 64'(2'b10));
    run_req("post_rst", mk_opc(4'h0, BR_NONE, 4'hF), t, e);
    check("post_rst_take", 64'({t, e}), 64'(2'b10));
    check_cnts("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
